// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by data_memory_ctrl and mem_line_array.
//   LINE_W      - width of one memory line in bits (32-byte lines)
//   OFFSET_BITS - byte-offset bits of an address that select within a line
//   state_t     - request FSM states
//   idx_width() - line-index width for a given array depth
package mem_pkg;

    localparam int unsigned LINE_W      = 256;
    localparam int unsigned OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: single-port DEPTH x LINE_W synchronous line store.
// The storage has no reset, so a testbench can preload it hierarchically
// (r_mem). The read-data register is reset to zero and only updates on re_i.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-low reset (read-data register only)
//   we_i     - write enable, writes wdata_i to line idx_i
//   re_i     - read enable, registers line idx_i onto rdata_o
//   idx_i    - line index
//   wdata_i  - write line data
//   rdata_o  - registered read line data
module mem_line_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned IDX_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata <= '0;
        end else if (re_i) begin
            r_rdata <= r_mem[idx_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: fixed-latency off-chip data memory model serving
// 256-bit line refills and write-backs from the data-cache controller.
// A request is latched in IDLE, held for LATENCY cycles, then completed
// with a one-cycle ack_o pulse (and line data for reads).
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-low reset
//   addr_i   - byte address of the line, bits [4:0] ignored
//   data_i   - write line data
//   enable_i - request valid, held by requester until ack_o
//   write_i  - 1 = write line, 0 = read line
//   ack_o    - one-cycle completion pulse
//   data_o   - read line data, valid while ack_o = 1
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = idx_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 2);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [LINE_W-1:0]   r_wdata;
    logic                r_write;
    logic                r_ack;

    logic [IDX_W-1:0]    w_idx;
    logic                w_last;
    logic                w_rd_en;
    logic                w_we;
    logic                w_unused_addr;

    // Higher address bits wrap; low offset bits select bytes within a line.
    assign w_idx         = addr_i[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
    assign w_unused_addr = ^{addr_i[31:IDX_W+OFFSET_BITS], addr_i[OFFSET_BITS-1:0]};

    assign w_last  = (r_state == WAIT) && (r_cnt == CNT_LAST);
    // The array read is launched on the edge entering ACK and the write
    // commits on the edge leaving it, so the array is never read and
    // written in the same cycle.
    assign w_rd_en = w_last && !r_write;
    assign w_we    = (r_state == ACK) && r_write;

    // ack_o is registered from the ACK state, so it is seen LATENCY cycles
    // after acceptance, coinciding with the FSM already back in IDLE; that
    // is what lets a still-held enable_i be accepted on the next edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= (r_state == ACK);
            unique case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_idx   <= w_idx;
                        r_wdata <= data_i;
                        r_write <= write_i;
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mem_line_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_we),
        .re_i    (w_rd_en),
        .idx_i   (r_idx),
        .wdata_i (r_wdata),
        .rdata_o (data_o)
    );

    assign ack_o = r_ack;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 512;
    localparam int LAT0 = 10;
    localparam int LAT1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [31:0]       addr [2];
    logic [LINE_W-1:0] din  [2];
    logic              en   [2];
    logic              wr   [2];
    logic              ack  [2];
    logic [LINE_W-1:0] dout [2];

    logic [LINE_W-1:0] model [2][DEPTH];

    int checks   = 0;
    int failures = 0;

    data_memory_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut10 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr[0]), .data_i(din[0]),
        .enable_i(en[0]), .write_i(wr[0]), .ack_o(ack[0]), .data_o(dout[0])
    );

    data_memory_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr[1]), .data_i(din[1]),
        .enable_i(en[1]), .write_i(wr[1]), .ack_o(ack[1]), .data_o(dout[1])
    );

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int unsigned line_of(input logic [31:0] a);
        return (a / 32) % DEPTH;
    endfunction

    task automatic preload(input int u, input int unsigned line, input logic [LINE_W-1:0] v);
        model[u][line] = v;
        if (u == 0) u_dut10.u_array.r_mem[line] = v;
        else        u_dut2.u_array.r_mem[line]  = v;
    endtask

    // One complete request: returns cycles from accepting edge to ack,
    // the data seen with ack, whether the wait expired, and ack one cycle later.
    task automatic txn(input int u, input logic [31:0] a, input logic [LINE_W-1:0] d,
                       input logic w, output int lat, output logic [LINE_W-1:0] rd,
                       output logic to, output logic ack_next);
        int lim;
        lim = (u == 0) ? LAT0 : LAT1;
        @(negedge clk);
        addr[u] = a; din[u] = d; wr[u] = w; en[u] = 1'b1;
        @(posedge clk);
        to = 1'b1; lat = 0; rd = '0; ack_next = 1'b0;
        for (int c = 1; c <= lim + 6; c++) begin
            @(posedge clk); #1;
            if (ack[u]) begin
                lat = c; rd = dout[u]; to = 1'b0;
                break;
            end
        end
        en[u] = 1'b0;
        if (!to) begin
            @(posedge clk); #1;
            ack_next = ack[u];
            if (w) model[u][line_of(a)] = d;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (ack[u] !== 1'b0) begin
                failures++; $display("FAIL reset_ack u%0d: got %b want 0", u, ack[u]);
            end
            checks++;
            if (dout[u] !== '0) begin
                failures++; $display("FAIL reset_data u%0d: got %h want 0", u, dout[u]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_read();
        int lat; logic [LINE_W-1:0] rd; logic to, an;
        for (int u = 0; u < 2; u++) begin
            preload(u, 3, {32{8'hA5}});
            txn(u, 32'h60, '0, 1'b0, lat, rd, to, an);
            checks++;
            if (to || lat != ((u == 0) ? LAT0 : LAT1)) begin
                failures++; $display("FAIL read_latency u%0d: got %0d (timeout=%b) want %0d", u, lat, to, (u == 0) ? LAT0 : LAT1);
            end
            checks++;
            if (rd !== {32{8'hA5}}) begin
                failures++; $display("FAIL read_data u%0d: got %h want a5..a5", u, rd);
            end
            checks++;
            if (an !== 1'b0) begin
                failures++; $display("FAIL ack_width u%0d: ack still %b next cycle want 0", u, an);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [LINE_W-1:0] rd, prev; logic to, an;
        for (int u = 0; u < 2; u++) begin
            prev = dout[u];
            txn(u, 32'h80, 256'h1234, 1'b1, lat, rd, to, an);
            checks++;
            if (to || rd !== prev) begin
                failures++; $display("FAIL write_keeps_data u%0d: got %h (timeout=%b) want %h", u, rd, to, prev);
            end
            txn(u, 32'h80, '0, 1'b0, lat, rd, to, an);
            checks++;
            if (to || rd !== 256'h1234) begin
                failures++; $display("FAIL read_after_write u%0d: got %h want 1234", u, rd);
            end
            txn(u, 32'h60, '0, 1'b0, lat, rd, to, an);
            checks++;
            if (to || rd !== model[u][3]) begin
                failures++; $display("FAIL line3_intact u%0d: got %h want %h", u, rd, model[u][3]);
            end
            txn(u, 32'hA0, '0, 1'b0, lat, rd, to, an);
            checks++;
            if (to || rd !== model[u][5]) begin
                failures++; $display("FAIL line5_intact u%0d: got %h want %h", u, rd, model[u][5]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [LINE_W-1:0] d1, d2;
        int first, second;
        a = $urandom; b = $urandom;
        d1 = '0; d2 = '0;
        @(negedge clk);
        addr[0] = a; wr[0] = 1'b0; din[0] = rand_line(); en[0] = 1'b1;
        @(posedge clk);
        first = -1; second = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ack[0]) begin
                if (first < 0) begin
                    first = c; d1 = dout[0];
                    addr[0] = b; wr[0] = 1'b0;
                end else begin
                    second = c; d2 = dout[0];
                    break;
                end
            end else begin
                // Noise on the request lines while the controller is busy.
                addr[0] = $urandom; wr[0] = 1'($urandom); din[0] = rand_line();
            end
        end
        en[0] = 1'b0; wr[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (first != LAT0) begin
            failures++; $display("FAIL b2b_first_latency: got %0d want %0d", first, LAT0);
        end
        checks++;
        if (second < 0 || second - first != LAT0 + 1) begin
            failures++; $display("FAIL b2b_spacing: got %0d want %0d", second - first, LAT0 + 1);
        end
        checks++;
        if (d1 !== model[0][line_of(a)]) begin
            failures++; $display("FAIL b2b_data1: got %h want %h", d1, model[0][line_of(a)]);
        end
        checks++;
        if (d2 !== model[0][line_of(b)]) begin
            failures++; $display("FAIL b2b_data2: got %h want %h", d2, model[0][line_of(b)]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [LINE_W-1:0] old, rd;
        int lat; logic to, an, seen;
        old = model[0][2];
        @(negedge clk);
        addr[0] = 32'h40; din[0] = ~old; wr[0] = 1'b1; en[0] = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0; en[0] = 1'b0; wr[0] = 1'b0;
        #1;
        checks++;
        if (dout[0] !== '0 || ack[0] !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs: got ack=%b data=%h want 0/0", ack[0], dout[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ack[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL midreset_no_ack: got ack pulse=%b want 0", seen);
        end
        txn(0, 32'h40, '0, 1'b0, lat, rd, to, an);
        checks++;
        if (to || rd !== old) begin
            failures++; $display("FAIL midreset_write_dropped: got %h want %h", rd, old);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [LINE_W-1:0] rd, nd; logic to, an;
        txn(0, 32'h4060, '0, 1'b0, lat, rd, to, an);
        checks++;
        if (to || rd !== model[0][3]) begin
            failures++; $display("FAIL wrap_4060: got %h want %h", rd, model[0][3]);
        end
        txn(0, 32'h7F, '0, 1'b0, lat, rd, to, an);
        checks++;
        if (to || rd !== model[0][3]) begin
            failures++; $display("FAIL offset_ignored_7f: got %h want %h", rd, model[0][3]);
        end
        nd = rand_line();
        txn(0, 32'hFFFF_C0BF, nd, 1'b1, lat, rd, to, an);
        txn(0, 32'hA0, '0, 1'b0, lat, rd, to, an);
        checks++;
        if (to || rd !== nd) begin
            failures++; $display("FAIL wrap_high_write: got %h want %h", rd, nd);
        end
    endtask

    task automatic test_random();
        int lat; logic [LINE_W-1:0] rd, prev, nd; logic to, an, w;
        logic [31:0] a;
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 25; n++) begin
                a = $urandom;
                w = 1'($urandom);
                nd = rand_line();
                prev = dout[u];
                txn(u, a, nd, w, lat, rd, to, an);
                checks++;
                if (to || lat != ((u == 0) ? LAT0 : LAT1) || an !== 1'b0) begin
                    failures++; $display("FAIL rand_timing u%0d n%0d: lat=%0d timeout=%b ack_next=%b", u, n, lat, to, an);
                end
                checks++;
                if (rd !== (w ? prev : model[u][line_of(a)])) begin
                    failures++; $display("FAIL rand_data u%0d n%0d: got %h want %h", u, n, rd, w ? prev : model[u][line_of(a)]);
                end
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            addr[u] = '0; din[u] = '0; en[u] = 1'b0; wr[u] = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) preload(u, i, rand_line());
        end
        test_reset();
        test_basic_read();
        test_write_read();
        test_back_to_back();
        test_reset_mid_write();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
